// File: rtl/shift_serializer_hs.sv
// rtl/shift_serializer_hs.sv - FROM-to-TO parallel-to-serial converter with valid/ready on both sides
module shift_serializer_hs #(
    parameter int FROM      = 32,
    parameter int TO        = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear_i,
    input  logic [FROM-1:0] data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [TO-1:0]   data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            last_o,
    output logic            busy_o
);

    localparam int R  = FROM / TO;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(R - 1);

    if ((TO < 1) || (TO > FROM) || ((FROM % TO) != 0)) begin : g_bad_params
        $error("shift_serializer_hs: FROM must be a non-zero multiple of TO");
    end

    // State encoding is {act_v, pend_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b10,
        FULL   = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [FROM-1:0] act_q, act_d;
    logic [FROM-1:0] pend_q, pend_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [FROM-1:0] act_shift;
    logic            accept, consume, done;

    // The outgoing chunk always sits at one end of the active register.
    if (R == 1) begin : g_no_shift
        assign act_shift = act_q;
    end else if (MSB_FIRST != 0) begin : g_shift_left
        assign act_shift = {act_q[FROM-TO-1:0], {TO{1'b0}}};
    end else begin : g_shift_right
        assign act_shift = {{TO{1'b0}}, act_q[FROM-1:TO]};
    end

    assign data_o  = (MSB_FIRST != 0) ? act_q[FROM-1 -: TO] : act_q[TO-1:0];
    assign valid_o = state_q[1];
    assign ready_o = !state_q[0];
    assign busy_o  = state_q[1] | state_q[0];
    assign last_o  = valid_o && (beat_q == LAST_BEAT);

    assign accept  = valid_i && ready_o;
    assign consume = valid_o && ready_i;
    assign done    = consume && last_o;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        beat_d  = beat_q;
        if (clear_i) begin
            state_d = EMPTY;
            beat_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        act_d   = data_i;
                        beat_d  = '0;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (consume && !last_o) begin
                        act_d  = act_shift;
                        beat_d = beat_q + CW'(1);
                    end
                    if (done) begin
                        if (accept) begin
                            act_d  = data_i;
                            beat_d = '0;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (accept) begin
                        pend_d  = data_i;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (consume && !last_o) begin
                        act_d  = act_shift;
                        beat_d = beat_q + CW'(1);
                    end
                    if (done) begin
                        act_d   = pend_q;
                        beat_d  = '0;
                        state_d = ACTIVE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    beat_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            act_q   <= '0;
            pend_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_shift_serializer_hs.sv
// tb/tb_shift_serializer_hs.sv - directed self-checking bench for shift_serializer_hs
module tb_shift_serializer_hs;

    logic        clk = 1'b0;
    logic        reset_n, clear_i, valid_i, ready_i;
    logic [31:0] din;

    logic       m8_ready, m8_valid, m8_last, m8_busy;
    logic [1:0] m8_data;
    logic       l8_ready, l8_valid, l8_last, l8_busy;
    logic [1:0] l8_data;
    logic       w32_ready, w32_valid, w32_last, w32_busy;
    logic [3:0] w32_data;
    logic       r1_ready, r1_valid, r1_last, r1_busy;
    logic [3:0] r1_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_serializer_hs #(.FROM(8), .TO(2), .MSB_FIRST(1)) u_m8 (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .data_i(din[7:0]),
        .valid_i(valid_i), .ready_o(m8_ready), .data_o(m8_data), .valid_o(m8_valid),
        .ready_i(ready_i), .last_o(m8_last), .busy_o(m8_busy));

    shift_serializer_hs #(.FROM(8), .TO(2), .MSB_FIRST(0)) u_l8 (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .data_i(din[7:0]),
        .valid_i(valid_i), .ready_o(l8_ready), .data_o(l8_data), .valid_o(l8_valid),
        .ready_i(ready_i), .last_o(l8_last), .busy_o(l8_busy));

    shift_serializer_hs #(.FROM(32), .TO(4), .MSB_FIRST(1)) u_w32 (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .data_i(din),
        .valid_i(valid_i), .ready_o(w32_ready), .data_o(w32_data), .valid_o(w32_valid),
        .ready_i(ready_i), .last_o(w32_last), .busy_o(w32_busy));

    shift_serializer_hs #(.FROM(4), .TO(4), .MSB_FIRST(1)) u_r1 (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .data_i(din[3:0]),
        .valid_i(valid_i), .ready_o(r1_ready), .data_o(r1_data), .valid_o(r1_valid),
        .ready_i(ready_i), .last_o(r1_last), .busy_o(r1_busy));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; din = '0;
        tick; tick;
        checks++; if ({m8_valid, m8_last, m8_busy, m8_ready, m8_data} !== 6'b000100) begin errors++; $display("FAIL reset_m8 got %b exp 000100", {m8_valid, m8_last, m8_busy, m8_ready, m8_data}); end
        checks++; if ({w32_valid, w32_last, w32_busy, w32_ready, w32_data} !== 8'b00010000) begin errors++; $display("FAIL reset_w32 got %b exp 00010000", {w32_valid, w32_last, w32_busy, w32_ready, w32_data}); end
        checks++; if ({r1_valid, r1_last, r1_busy, r1_ready, r1_data} !== 8'b00010000) begin errors++; $display("FAIL reset_r1 got %b exp 00010000", {r1_valid, r1_last, r1_busy, r1_ready, r1_data}); end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        logic [1:0] msb_exp [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0] lsb_exp [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        din = 32'h0000_00B4; valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({m8_valid, m8_last, m8_data} !== {1'b1, i == 3, msb_exp[i]}) begin errors++; $display("FAIL single_msb[%0d] got v/l/d=%b exp %b", i, {m8_valid, m8_last, m8_data}, {1'b1, i == 3, msb_exp[i]}); end
            checks++; if ({l8_valid, l8_last, l8_data} !== {1'b1, i == 3, lsb_exp[i]}) begin errors++; $display("FAIL single_lsb[%0d] got v/l/d=%b exp %b", i, {l8_valid, l8_last, l8_data}, {1'b1, i == 3, lsb_exp[i]}); end
            tick;
        end
        checks++; if ({m8_valid, l8_valid, m8_last} !== 3'b000) begin errors++; $display("FAIL single_idle got %b exp 000", {m8_valid, l8_valid, m8_last}); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
        din = 32'h0000_00B4; valid_i = 1'b1;
        tick;
        din = 32'h0000_005A;
        for (int i = 0; i < 8; i++) begin
            checks++; if ({m8_valid, m8_last, m8_data} !== {1'b1, (i % 4) == 3, exp[i]}) begin errors++; $display("FAIL b2b_beat[%0d] got v/l/d=%b exp %b", i, {m8_valid, m8_last, m8_data}, {1'b1, (i % 4) == 3, exp[i]}); end
            checks++; if (m8_ready !== !(i >= 1 && i <= 3)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, m8_ready, !(i >= 1 && i <= 3)); end
            tick;
            valid_i = 1'b0;
        end
        checks++; if (m8_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", m8_valid); end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11};
        din = 32'h0000_00B4; valid_i = 1'b1;
        tick;
        din = 32'h0000_005A;
        tick;
        din = 32'h0000_00C3; ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if ({m8_valid, m8_last, m8_data, m8_ready} !== 5'b10110) begin errors++; $display("FAIL bp_stall[%0d] got v/l/d/r=%b exp 10110", i, {m8_valid, m8_last, m8_data, m8_ready}); end
        end
        ready_i = 1'b1;
        tick;
        checks++; if ({m8_last, m8_data, m8_ready} !== 4'b0010) begin errors++; $display("FAIL bp_beat2 got l/d/r=%b exp 0010", {m8_last, m8_data, m8_ready}); end
        tick;
        checks++; if ({m8_last, m8_data, m8_ready} !== 4'b1000) begin errors++; $display("FAIL bp_beat3 got l/d/r=%b exp 1000", {m8_last, m8_data, m8_ready}); end
        tick;
        for (int i = 0; i < 8; i++) begin
            checks++; if ({m8_valid, m8_last, m8_data} !== {1'b1, (i % 4) == 3, exp[i]}) begin errors++; $display("FAIL bp_beat[%0d] got v/l/d=%b exp %b", i, {m8_valid, m8_last, m8_data}, {1'b1, (i % 4) == 3, exp[i]}); end
            checks++; if (m8_ready !== !(i >= 1 && i <= 3)) begin errors++; $display("FAIL bp_ready[%0d] got %b exp %b", i, m8_ready, !(i >= 1 && i <= 3)); end
            tick;
            valid_i = 1'b0;
        end
        checks++; if (m8_busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got %b exp 0", m8_busy); end
    endtask

    task automatic test_clear;
        logic [1:0] exp [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        din = 32'h0000_00B4; valid_i = 1'b1;
        tick;
        din = 32'h0000_005A;
        tick;
        tick;
        din = 32'h0000_00C3; clear_i = 1'b1;
        checks++; if ({m8_data, m8_ready} !== 3'b010) begin errors++; $display("FAIL clr_pre got d/r=%b exp 010", {m8_data, m8_ready}); end
        tick;
        clear_i = 1'b0; valid_i = 1'b0;
        checks++; if ({m8_valid, m8_busy, m8_ready, m8_last} !== 4'b0010) begin errors++; $display("FAIL clr_full got v/b/r/l=%b exp 0010", {m8_valid, m8_busy, m8_ready, m8_last}); end
        tick;
        checks++; if ({m8_valid, m8_busy} !== 2'b00) begin errors++; $display("FAIL clr_stay got %b exp 00", {m8_valid, m8_busy}); end
        clear_i = 1'b1; valid_i = 1'b1;
        tick;
        clear_i = 1'b0; valid_i = 1'b0;
        checks++; if ({m8_valid, m8_busy} !== 2'b00) begin errors++; $display("FAIL clr_drop_empty got %b exp 00", {m8_valid, m8_busy}); end
        din = 32'h0000_005A; valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({m8_valid, m8_last, m8_data} !== {1'b1, i == 3, exp[i]}) begin errors++; $display("FAIL clr_restart[%0d] got v/l/d=%b exp %b", i, {m8_valid, m8_last, m8_data}, {1'b1, i == 3, exp[i]}); end
            tick;
        end
    endtask

    task automatic test_reset_midword;
        logic [3:0] w_exp [8] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h0, 4'hF, 4'h9, 4'h6};
        logic [1:0] m_exp [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
        din = 32'h1234_56B4; valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
        tick;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({m8_valid, m8_last, m8_busy, m8_ready, m8_data} !== 6'b000100) begin errors++; $display("FAIL rst_mid_m8 got %b exp 000100", {m8_valid, m8_last, m8_busy, m8_ready, m8_data}); end
        checks++; if ({w32_valid, w32_last, w32_busy, w32_ready, w32_data} !== 8'b00010000) begin errors++; $display("FAIL rst_mid_w32 got %b exp 00010000", {w32_valid, w32_last, w32_busy, w32_ready, w32_data}); end
        checks++; if ({r1_valid, r1_last, r1_busy, r1_ready, r1_data} !== 8'b00010000) begin errors++; $display("FAIL rst_mid_r1 got %b exp 00010000", {r1_valid, r1_last, r1_busy, r1_ready, r1_data}); end
        tick;
        reset_n = 1'b1;
        tick;
        din = 32'hA5C3_0F96; valid_i = 1'b1;
        tick;
        valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if ({w32_valid, w32_last, w32_data} !== {1'b1, i == 7, w_exp[i]}) begin errors++; $display("FAIL rst_w32[%0d] got v/l/d=%b exp %b", i, {w32_valid, w32_last, w32_data}, {1'b1, i == 7, w_exp[i]}); end
            if (i < 4) begin
                checks++; if ({m8_valid, m8_last, m8_data} !== {1'b1, i == 3, m_exp[i]}) begin errors++; $display("FAIL rst_m8[%0d] got v/l/d=%b exp %b", i, {m8_valid, m8_last, m8_data}, {1'b1, i == 3, m_exp[i]}); end
            end
            if (i == 0) begin
                checks++; if ({r1_valid, r1_last, r1_data} !== 6'b110110) begin errors++; $display("FAIL rst_r1_beat got v/l/d=%b exp 110110", {r1_valid, r1_last, r1_data}); end
            end else if (i == 1) begin
                checks++; if ({r1_valid, r1_busy} !== 2'b00) begin errors++; $display("FAIL rst_r1_idle got %b exp 00", {r1_valid, r1_busy}); end
            end
            tick;
        end
        checks++; if ({w32_valid, m8_valid} !== 2'b00) begin errors++; $display("FAIL rst_final_idle got %b exp 00", {w32_valid, m8_valid}); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_clear;
        test_reset_midword;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_serializer_hs.md
Name: shift_serializer_hs

Overview:
- Parametrised FROM-to-TO parallel-to-serial converter with valid/ready handshakes on both sides.
- Each accepted FROM-bit word is emitted as R = FROM/TO beats of TO bits.
- Adds backpressure handling, a one-word pending buffer for bubble-free back-to-back streaming, selectable beat order, a last-beat flag and a synchronous clear.
- Sits between wide datapath producers and narrow link/IO stages in the mixed serializer path.

Parameters:
FROM, 32, input word width in bits; must be a multiple of TO.
TO, 4, output beat width in bits; 1 <= TO <= FROM.
MSB_FIRST, 1, 1 = most-significant TO-bit chunk is sent first; 0 = least-significant chunk first.
(derived) R = FROM/TO beats per word; CW = max(1, $clog2(R)) counter width.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
clear_i  input  1  synchronous flush of all stored words (active high)
data_i  input  FROM  parallel input word
valid_i  input  1  data_i valid
ready_o  input-side output  1  block can accept data_i this cycle
data_o  output  TO  current serial beat
valid_o  output  1  data_o valid
ready_i  input  1  downstream accepts data_o this cycle
last_o  output  1  data_o is the final beat (beat R-1) of its word
busy_o  output  1  active or pending word held

Behaviour:
- Storage: active shift register (FROM bits, valid flag act_v, beat counter beat_q 0..R-1) plus pending register (FROM bits, flag pend_v).
- Chunk k of a word = word[k*TO +: TO].
  - MSB_FIRST=1: beat b carries chunk R-1-b.
  - MSB_FIRST=0: beat b carries chunk b.
- Beat selection is done by shifting the active register by TO each beat, not by a wide mux.
- Handshakes:
  - Input accepted when valid_i && ready_o; ready_o = !pend_v (combinational from state only, not from valid_i or ready_i).
  - Output beat consumed when valid_o && ready_i.
  - valid_o = act_v; data_o and valid_o hold stable while valid_o && !ready_i.
- last_o = act_v && (beat_q == R-1).
- busy_o = act_v || pend_v.
- Define done = valid_o && ready_i && last_o.
- FSM states on (act_v, pend_v):
  - EMPTY (0,0):
    - accept -> load active, beat_q=0 -> ACTIVE.
  - ACTIVE (1,0):
    - Non-last consume -> shift, beat_q+1.
    - done with accept -> load input into active, beat_q=0 (no bubble).
    - done without accept -> EMPTY.
    - accept without done -> store to pending -> FULL.
  - FULL (1,1): ready_o=0.
    - Non-last consume -> shift, beat_q+1.
    - done -> move pending to active, beat_q=0, pend_v=0 -> ACTIVE.
- Latency: word accepted in cycle t from EMPTY presents its first beat (valid_o=1) in cycle t+1.
- Throughput: with ready_i held high and valid_i continuous, one beat per cycle, zero idle cycles between words.
- R=1: every beat is last; behaves as a 2-deep registered pipeline.
- Wrap-around: beat_q returns to 0 only on a load; it never overflows past R-1.
- clear_i (sync):
  - Next cycle act_v=0, pend_v=0, beat_q=0.
  - clear_i has priority over any simultaneous accept or consume; the input word offered in that cycle is dropped, even though ready_o may read 1.
- Reset (asynchronous assert, any time including mid-word):
  - Registers go to act_v=0, pend_v=0, beat_q=0, data registers 0.
  - Outputs valid_o=0, last_o=0, busy_o=0, data_o=0, ready_o=1.
  - Partially sent words are discarded.
  - Deassertion is assumed synchronised externally.
- Elaboration error if FROM % TO != 0 or TO > FROM.

Test Plan:
- FROM=8, TO=2, MSB_FIRST=1, ready_i=1: send 0xB4 -> beats 2'b10,2'b11,2'b01,2'b00 in cycles t+1..t+4, last_o only on the 4th, then valid_o=0.
- Same config, MSB_FIRST=0: send 0xB4 -> beats 2'b00,2'b01,2'b11,2'b10.
- Back-to-back 0xB4,0x5A with valid_i and ready_i always high -> 8 consecutive valid beats 10,11,01,00,01,01,10,10, no gap, ready_o drops to 0 while pending is held.
- Backpressure: ready_i=0 for 3 cycles in mid-word -> data_o/last_o frozen, beat_q unchanged; a third offered word sees ready_o=0 until the first word's last beat is consumed.
- clear_i asserted on beat 2 with pending full and valid_i=1 -> next cycle valid_o=0, busy_o=0, ready_o=1, offered word dropped; a later word restarts at beat 0.
- reset_n pulsed low mid-word (also with FROM=32, TO=4, and with R=1 at FROM=TO=4) -> outputs immediately at reset values; after release a fresh word serialises correctly from beat 0.
